// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t X0 = 5'd0;

  // Field order matches the pipeline-control outputs, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE      = 5'b11000;
  localparam ctrl_t CTRL_MEM_STALL = 5'b00001;
  localparam ctrl_t CTRL_FLUSH     = 5'b11110;
  localparam ctrl_t CTRL_LU_STALL  = 5'b00010;
  localparam ctrl_t CTRL_RESET     = 5'b00110;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if;

  hazard_pkg::reg_idx_t IF_ID_Rs1;
  hazard_pkg::reg_idx_t IF_ID_Rs2;
  hazard_pkg::reg_idx_t ID_EX_Rd;
  logic                 ID_EX_MemRead;
  logic                 EX_BranchTaken;
  logic                 EX_MEM_MemAccess;
  logic                 dmem_ready;
  logic                 PC_Write;
  logic                 IF_ID_Write;
  logic                 IF_ID_Flush;
  logic                 ID_EX_Flush;
  logic                 EX_MEM_Hold;

  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd, ID_EX_MemRead,
    output EX_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold
  );

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd, ID_EX_MemRead,
    input  EX_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Purely combinational load-use hazard detector; loads into x0 never stall.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic     mem_read,
  input  reg_idx_t rd,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     hazard
);

  assign hazard = mem_read && (rd != X0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stall > taken branch > load-use, Mealy outputs.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus,
  output logic [1:0]    state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  state_t state, state_nxt;
  logic   pend_flush, pend_nxt;
  logic   lu, ms;
  ctrl_t  ctrl;

  load_use_detect u_lu (
    .mem_read (bus.ID_EX_MemRead),
    .rd       (bus.ID_EX_Rd),
    .rs1      (bus.IF_ID_Rs1),
    .rs2      (bus.IF_ID_Rs2),
    .hazard   (lu)
  );

  assign ms = bus.EX_MEM_MemAccess && !bus.dmem_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_flush <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_nxt;
    end
  end

  // A branch that lands inside a memory wait is remembered and replayed as REDIRECT.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt = state;
    pend_nxt  = pend_flush;
    case (state)
      RUN: begin
        if (ms) begin
          state_nxt = MEM_WAIT;
          pend_nxt  = pend_flush | bus.EX_BranchTaken;
        end
      end
      MEM_WAIT: begin
        if (ms) begin
          pend_nxt = pend_flush | bus.EX_BranchTaken;
        end else begin
          state_nxt = pend_flush ? REDIRECT : RUN;
          pend_nxt  = 1'b0;
        end
      end
      REDIRECT: begin
        if (ms) begin
          state_nxt = MEM_WAIT;
          pend_nxt  = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (ms) begin
      ctrl = CTRL_MEM_STALL;
    end else begin
      case (state)
        RUN: begin
          if (bus.EX_BranchTaken) ctrl = CTRL_FLUSH;
          else if (lu)            ctrl = CTRL_LU_STALL;
        end
        REDIRECT: ctrl = CTRL_FLUSH;
        default:  ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign bus.PC_Write    = ctrl.pc_write;
  assign bus.IF_ID_Write = ctrl.if_id_write;
  assign bus.IF_ID_Flush = ctrl.if_id_flush;
  assign bus.ID_EX_Flush = ctrl.id_ex_flush;
  assign bus.EX_MEM_Hold = ctrl.ex_mem_hold;
  assign state_o         = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ctrl.if_id_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic vs a cycle model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: "waiting on memory", "redirect owed next cycle", "branch remembered".
  bit m_wait  = 1'b0;
  bit m_redir = 1'b0;
  bit m_pend  = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare Mealy outputs 1 ns later, then advance the model.
  task automatic step(input string tag, input bit rst, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit [4:0] rd, input bit mr, input bit br, input bit acc, input bit rdy);
    bit       ms, lu;
    bit [4:0] exp;
    bit [1:0] exp_state;
    @(negedge clk);
    rst_n                = rst;
    bus.IF_ID_Rs1        = rs1;
    bus.IF_ID_Rs2        = rs2;
    bus.ID_EX_Rd         = rd;
    bus.ID_EX_MemRead    = mr;
    bus.EX_BranchTaken   = br;
    bus.EX_MEM_MemAccess = acc;
    bus.dmem_ready       = rdy;
    #1;
    ms = acc && !rdy;
    lu = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    exp_state = m_wait ? 2'd1 : (m_redir ? 2'd2 : 2'd0);
    // Output order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold
    if (!rst)                 exp = 5'b00110;
    else if (ms)              exp = 5'b00001;
    else if (m_wait)          exp = 5'b11000;
    else if (m_redir || br)   exp = 5'b11110;
    else if (lu)              exp = 5'b00010;
    else                      exp = 5'b11000;
    check({tag, " outs"}, {27'd0, bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush,
                           bus.ID_EX_Flush, bus.EX_MEM_Hold}, {27'd0, exp});
    check({tag, " state"}, {30'd0, state_o}, {30'd0, exp_state});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, " stall_cnt"}, {16'd0, stall_cnt}, m_stall);
    check({tag, " flush_cnt"}, {16'd0, flush_cnt}, m_flush);
`endif
    if (!rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!exp[4] && m_stall < 65535) m_stall++;
      if (exp[2] && m_flush < 65535)  m_flush++;
    end
    if (!rst) begin
      m_wait = 1'b0; m_redir = 1'b0; m_pend = 1'b0;
    end else if (ms) begin
      m_pend  = m_pend | br | m_redir;
      m_wait  = 1'b1;
      m_redir = 1'b0;
    end else if (m_wait) begin
      m_wait  = 1'b0;
      m_redir = m_pend;
      m_pend  = 1'b0;
    end else begin
      m_redir = 1'b0;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
  endtask

  task automatic mem(input string tag, input bit br, input bit rdy);
    step(tag, 1, 5'd1, 5'd2, 5'd3, 0, br, 1, rdy);
  endtask

  initial begin
    bit       r, mr, br, acc, rdy;
    bit [4:0] rs1, rs2, rd;

    step("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0, 0, 1, 1, 0);
    idle("idle");

    step("lu_stall", 1, 5'd7, 5'd5, 5'd5, 1, 0, 0, 0);
    step("lu_bubble", 1, 5'd7, 5'd5, 5'd5, 0, 0, 0, 0);
    step("x0_load", 1, 5'd0, 5'd9, 5'd0, 1, 0, 0, 0);
    step("br_lu", 1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0);
    idle("br_lu_after");

    mem("mw_br1", 1, 0);
    mem("mw_2", 0, 0);
    mem("mw_3", 0, 0);
    mem("mw_ready", 0, 1);
    idle("mw_redirect");
    idle("mw_run");

    mem("redir_ms_br", 1, 0);
    mem("redir_ms_rdy", 0, 1);
    mem("redir_ms_hit", 0, 0);
    mem("redir_ms_rdy2", 0, 1);
    idle("redir_ms_redirect");
    idle("redir_ms_run");

    mem("rst_mw_br", 1, 0);
    mem("rst_mw_wait", 0, 0);
    step("rst_mw_rst", 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    idle("rst_mw_after0");
    idle("rst_mw_after1");

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 39) != 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      mr  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 4) == 0);
      acc = ($urandom_range(0, 2) == 0);
      rdy = 1'($urandom_range(0, 1));
      step("rand", r, rs1, rs2, rd, mr, br, acc, rdy);
    end

`ifdef HAZARD_PERF_CNT_EN
    step("cnt_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) mem("cnt_sat", 0, 0);
    mem("cnt_hold", 0, 0);
    check("stall_cnt_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
